div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the iterative divider that sits beside the EX stage:
//   - DivFree / DivByZero / DivOn / DivEnd : 2-bit divider FSM state encodings
//   - DivResultReady / DivResultNotReady   : values driven on ready_o
//   - DivStart / DivStop                   : values of the start_i request
//   - DoubleRegBus                         : width of the {remainder, quotient} bus
// -----------------------------------------------------------------------------
package div_unit_pkg;

   localparam int   DoubleRegBus      = 64;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider (signed div / unsigned divu), one quotient bit
// per clock. A divide by a nonzero divisor produces its result 33 edges after
// the edge that samples start_i; a zero divisor yields an all-zero result on
// the second edge.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset
//   signed_div_i  in   1   1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     in  32   dividend; sampled with start_i
//   opdata2_i     in  32   divisor;  sampled with start_i
//   start_i       in   1   request, held high by EX until ready_o is seen
//   annul_i       in   1   cancel an in-flight divide (pipeline flush)
//   result_o      out 64   {remainder, quotient}, registered
//   ready_o       out  1   result valid, registered
//   stallreq_o    out  1   combinational stall request for the EX stage
// -----------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [31:0]             opdata1_i,
   input  logic [31:0]             opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o,
   output logic                    stallreq_o
);

   div_state_t   state_reg;
   logic [5:0]   cnt_reg;
   logic [64:0]  work_reg;       // {partial remainder, remaining dividend bits / quotient bits}
   logic [31:0]  divisor_reg;    // divisor magnitude
   logic         neg_quot_reg;   // quotient must be negated at completion
   logic         neg_rem_reg;    // remainder must be negated at completion

   logic [31:0]  mag1;
   logic [31:0]  mag2;
   logic [32:0]  diff;
   logic [64:0]  work_next;
   logic [31:0]  quot_fix;
   logic [31:0]  rem_fix;

   always_comb begin
      // Operand magnitudes; unsigned mode passes the operands through.
      mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

      // One restoring step: try subtracting the divisor from the partial
      // remainder; a borrow (diff[32]) means the trial failed and the quotient
      // bit shifted in is 0.
      diff = {1'b0, work_reg[63:32]} - {1'b0, divisor_reg};
      if (diff[32]) begin
         work_next = {work_reg[63:0], 1'b0};
      end else begin
         work_next = {diff[31:0], work_reg[31:0], 1'b1};
      end

      // Sign fixup applied to the step that completes the divide, so the
      // result is registered on the same edge as the final step.
      quot_fix = neg_quot_reg ? (~work_next[31:0]  + 32'd1) : work_next[31:0];
      rem_fix  = neg_rem_reg  ? (~work_next[64:33] + 32'd1) : work_next[64:33];

      stallreq_o = !rst &&
                   ((state_reg == DivFree && start_i == DivStart && !annul_i) ||
                    state_reg == DivOn || state_reg == DivByZero);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= DivFree;
         cnt_reg      <= 6'd0;
         work_reg     <= 65'd0;
         divisor_reg  <= 32'd0;
         neg_quot_reg <= 1'b0;
         neg_rem_reg  <= 1'b0;
         result_o     <= '0;
         ready_o      <= DivResultNotReady;
      end else begin
         case (state_reg)
            DivFree: begin
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state_reg <= DivByZero;
                  end else begin
                     state_reg    <= DivOn;
                     cnt_reg      <= 6'd0;
                     work_reg     <= {32'd0, mag1, 1'b0};
                     divisor_reg  <= mag2;
                     // Quotient sign is the XOR of operand signs; the
                     // remainder follows the dividend.
                     neg_quot_reg <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                     neg_rem_reg  <= signed_div_i & opdata1_i[31];
                  end
               end
            end

            DivByZero: begin
               result_o <= '0;
               if (annul_i) begin
                  state_reg <= DivFree;
                  ready_o   <= DivResultNotReady;
               end else begin
                  state_reg <= DivEnd;
                  ready_o   <= DivResultReady;
               end
            end

            DivOn: begin
               // A flush wins over a completing step on the same edge.
               if (annul_i) begin
                  state_reg <= DivFree;
                  ready_o   <= DivResultNotReady;
                  result_o  <= '0;
               end else begin
                  work_reg <= work_next;
                  cnt_reg  <= cnt_reg + 6'd1;
                  if (cnt_reg == 6'd31) begin
                     state_reg <= DivEnd;
                     ready_o   <= DivResultReady;
                     result_o  <= {rem_fix, quot_fix};
                  end
               end
            end

            DivEnd: begin
               // Result is held until EX drops its request; annul_i is ignored.
               if (start_i == DivStop) begin
                  state_reg <= DivFree;
                  ready_o   <= DivResultNotReady;
                  result_o  <= '0;
               end
            end

            default: begin
               state_reg <= DivFree;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   int errors = 0;
   int checks = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready),
      .stallreq_o   (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Starts a divide, scrambles the operand inputs after the start edge,
   // measures the latency to ready, checks the result, optionally holds the
   // request for hold_n cycles, then drops it and checks the return to idle.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expv,
                          input int exp_lat, input int hold_n);
      int   n_edge;
      logic stall_ok;
      signed_div = sgn;
      op1        = a;
      op2        = b;
      start      = 1'b1;
      #1;
      chk($sformatf("%s_stall_at_request", tag), {63'd0, stallreq}, 64'd1);
      n_edge   = 0;
      stall_ok = 1'b1;
      while (n_edge < 40) begin
         tick();
         n_edge++;
         if (n_edge == 1) begin
            op1        = ~a;
            op2        = b ^ 32'h0000_5A5A;
            signed_div = ~sgn;
         end
         if (ready) break;
         if (!stallreq) stall_ok = 1'b0;
      end
      chk($sformatf("%s_latency", tag), 64'(n_edge), 64'(exp_lat));
      chk($sformatf("%s_stall_busy", tag), {63'd0, stall_ok}, 64'd1);
      chk($sformatf("%s_result", tag), result, expv);
      chk($sformatf("%s_stall_end", tag), {63'd0, stallreq}, 64'd0);
      for (int i = 0; i < hold_n; i++) begin
         tick();
         chk($sformatf("%s_hold_ready", tag), {63'd0, ready}, 64'd1);
         chk($sformatf("%s_hold_result", tag), result, expv);
      end
      start      = 1'b0;
      op1        = 32'd0;
      op2        = 32'd0;
      signed_div = 1'b0;
      tick();
      chk($sformatf("%s_idle_ready", tag), {63'd0, ready}, 64'd0);
      chk($sformatf("%s_idle_result", tag), result, 64'd0);
      chk($sformatf("%s_idle_stall", tag), {63'd0, stallreq}, 64'd0);
      $display("div %s: a=%h b=%h signed=%0d result=%h latency=%0d", tag, a, b, sgn, result, n_edge);
   endtask

   initial begin
      logic seen;

      // Reset with a pending request: outputs clean, no stall while rst=1.
      rst = 1'b1; signed_div = 1'b0; op1 = 32'd0; op2 = 32'd0; start = 1'b1; annul = 1'b0;
      tick();
      tick();
      chk("reset_ready", {63'd0, ready}, 64'd0);
      chk("reset_result", result, 64'd0);
      chk("reset_stall", {63'd0, stallreq}, 64'd0);
      $display("reset: ready=%0d result=%h stall=%0d", ready, result, stallreq);
      start = 1'b0;
      rst   = 1'b0;
      tick();

      run_div("u100_7",      1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                 33, 0);
      run_div("s_m7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 0);
      run_div("s_7_m2",      1'b1, 32'd7,         32'hFFFFFFFE,  {32'h00000001, 32'hFFFFFFFD},    33, 0);
      run_div("s_m100_m7",   1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE, 32'h0000000E},    33, 0);
      run_div("u_fff9_2",    1'b0, 32'hFFFFFFF9,  32'd2,         {32'h00000001, 32'h7FFFFFFC},    33, 0);
      run_div("u_ffff_16",   1'b0, 32'hFFFFFFFF,  32'h10,        {32'h0000000F, 32'h0FFFFFFF},    33, 0);
      run_div("u5_0_hold",   1'b0, 32'd5,         32'd0,         64'd0,                            2, 5);

      // Request while annul is high is ignored in FREE.
      annul = 1'b1; start = 1'b1; op2 = 32'd5; op1 = 32'd50;
      #1;
      chk("free_annul_stall", {63'd0, stallreq}, 64'd0);
      tick();
      tick();
      chk("free_annul_stay_stall", {63'd0, stallreq}, 64'd0);
      chk("free_annul_ready", {63'd0, ready}, 64'd0);
      annul = 1'b0; start = 1'b0;
      tick();
      $display("free with annul: stall=%0d ready=%0d", stallreq, ready);

      // Annul in BYZERO: back to FREE, no result.
      op1 = 32'd5; op2 = 32'd0; start = 1'b1;
      tick();
      chk("byzero_stall", {63'd0, stallreq}, 64'd1);
      annul = 1'b1; start = 1'b0;
      tick();
      chk("byzero_annul_ready", {63'd0, ready}, 64'd0);
      chk("byzero_annul_stall", {63'd0, stallreq}, 64'd0);
      annul = 1'b0;
      tick();
      chk("byzero_annul_no_result", {63'd0, ready}, 64'd0);
      $display("annul in byzero: ready=%0d result=%h", ready, result);

      // Annul in END has no effect; only dropping start exits.
      op1 = 32'd5; op2 = 32'd0; start = 1'b1;
      tick();
      tick();
      chk("end_ready", {63'd0, ready}, 64'd1);
      annul = 1'b1;
      tick();
      chk("end_annul_ready_held", {63'd0, ready}, 64'd1);
      annul = 1'b0; start = 1'b0;
      tick();
      chk("end_exit_ready", {63'd0, ready}, 64'd0);
      $display("annul in end: ready after exit=%0d", ready);

      // Annul during a long divide, then restart immediately.
      signed_div = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd1; start = 1'b1;
      repeat (10) tick();
      chk("annul_pre_ready", {63'd0, ready}, 64'd0);
      chk("annul_pre_stall", {63'd0, stallreq}, 64'd1);
      annul = 1'b1; start = 1'b0;
      tick();
      chk("annul_free_ready", {63'd0, ready}, 64'd0);
      chk("annul_free_result", result, 64'd0);
      chk("annul_free_stall", {63'd0, stallreq}, 64'd0);
      annul = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready) seen = 1'b1;
      end
      chk("annul_never_ready", {63'd0, seen}, 64'd0);
      $display("annul in on: ready seen=%0d", seen);
      run_div("u9_3_restart", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

      // Reset in the middle of a divide.
      signed_div = 1'b0; op1 = 32'h12345678; op2 = 32'h11; start = 1'b1;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      chk("midrst_ready", {63'd0, ready}, 64'd0);
      chk("midrst_result", result, 64'd0);
      chk("midrst_stall", {63'd0, stallreq}, 64'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      chk("postrst_ready", {63'd0, ready}, 64'd0);
      chk("postrst_result", result, 64'd0);
      chk("postrst_stall", {63'd0, stallreq}, 64'd0);
      $display("reset mid-divide: ready=%0d result=%h stall=%0d", ready, result, stallreq);
      run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
